tlb_query: RTL and testbench

TLB_QUERY -- requirements
Module: tlb_query

---
 rtl/tlb_query_pkg.sv | 60 ++++++
 rtl/tlb_entry_match.sv | 28 ++
 rtl/tlb_query.sv | 196 +++++++++++++++++++
 tb/tb_tlb_query.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_query_pkg.sv
// tlb_query_pkg
// Shared definitions for the TLB query engine (TLBP/TLBR execution):
//   - FSM state encoding
//   - TLBP / TLBR instruction encodings
//   - CP0 register numbers written by the engine
//   - bit positions of the fields inside a 96-bit TLB entry and in EntryHi
//   - probe-fail value and a helper that forms the Index write data
package tlb_query_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_PDONE  = 3'd2,
      ST_READ   = 3'd3,
      ST_WB_HI  = 3'd4,
      ST_WB_LO0 = 3'd5,
      ST_WB_LO1 = 3'd6
   } state_e;

   localparam logic [31:0] INST_TLBP = 32'h4200_0008;
   localparam logic [31:0] INST_TLBR = 32'h4200_0001;

   localparam logic [4:0] CP0_REG_INDEX    = 5'd0;
   localparam logic [4:0] CP0_REG_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_REG_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_REG_ENTRYHI  = 5'd10;

   // Index value reported when no entry matched (P bit set).
   localparam logic [31:0] PROBE_FAIL = 32'h8000_0000;

   // Entry layout: {EntryHi[95:64], EntryLo0[63:32], EntryLo1[31:0]}.
   localparam int ENT_EHI_HI  = 95;
   localparam int ENT_EHI_LO  = 64;
   localparam int ENT_LO0_HI  = 63;
   localparam int ENT_LO0_LO  = 32;
   localparam int ENT_LO1_HI  = 31;
   localparam int ENT_LO1_LO  = 0;
   localparam int ENT_VPN2_HI = 95;
   localparam int ENT_VPN2_LO = 77;
   localparam int ENT_ASID_HI = 71;
   localparam int ENT_ASID_LO = 64;

   // EntryHi layout.
   localparam int EHI_VPN2_HI = 31;
   localparam int EHI_VPN2_LO = 13;
   localparam int EHI_ASID_HI = 7;
   localparam int EHI_ASID_LO = 0;

   // Data written to CP0 Index at the end of a probe.
   function automatic logic [31:0] probe_result(input logic hit, input logic [3:0] idx);
      logic [31:0] res;
      if (hit) begin
         res = {28'd0, idx};
      end else begin
         res = PROBE_FAIL;
      end
      return res;
   endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// tlb_entry_match
// Compares one TLB entry against an EntryHi value: VPN2 and ASID must both
// be equal. Purely combinational so it can also sit in the translation path.
// Ports:
//   entry   in  96  TLB entry {EntryHi, EntryLo0, EntryLo1}
//   entryhi in  32  EntryHi to look up (VPN2 + ASID)
//   match   out  1  VPN2 and ASID equal
module tlb_entry_match
   import tlb_query_pkg::*;
(
   input  logic [95:0] entry,
   input  logic [31:0] entryhi,
   output logic        match
);

   logic vpn2_eq_s;
   logic asid_eq_s;
   logic unused_bits_s;

   assign vpn2_eq_s = (entry[ENT_VPN2_HI:ENT_VPN2_LO] == entryhi[EHI_VPN2_HI:EHI_VPN2_LO]);
   assign asid_eq_s = (entry[ENT_ASID_HI:ENT_ASID_LO] == entryhi[EHI_ASID_HI:EHI_ASID_LO]);
   assign match     = vpn2_eq_s & asid_eq_s;

   // Fields that take no part in the compare (G/flags, EntryLo words).
   assign unused_bits_s = ^{entry[ENT_VPN2_LO-1:ENT_ASID_HI+1], entry[ENT_LO0_HI:ENT_LO1_LO],
                            entryhi[EHI_VPN2_LO-1:EHI_ASID_HI+1]};

endmodule

// File: rtl/tlb_query.sv
// tlb_query
// Multi-cycle execution of TLBP (linear probe of 16 entries, lowest match
// wins) and TLBR (read one entry, write it back to CP0 over three cycles).
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   inst_i, inst_valid_i  EX-stage instruction and its valid
//   flush_i               pipeline flush, aborts any operation
//   index_i, entryhi_i    forwarded CP0 Index / EntryHi
//   rd_idx_o, rd_entry_i  TLB array read port (array lives outside)
//   stall_req_o           hold EX stage while the operation runs
//   busy_o                engine not idle
//   cp0_we_o/waddr/wdata  single CP0 write port
// All outputs are registered from the next-state decode; cp0_we_o is
// additionally masked by flush and reset so an abort cancels the write in
// the very cycle it is requested.
module tlb_query
   import tlb_query_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic        inst_valid_i,
   input  logic        flush_i,
   input  logic [31:0] index_i,
   input  logic [31:0] entryhi_i,
   output logic [3:0]  rd_idx_o,
   input  logic [95:0] rd_entry_i,
   output logic        stall_req_o,
   output logic        busy_o,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o
);

   state_e      state_r,  state_s;
   logic [3:0]  ptr_r,    ptr_s;
   logic        hit_r,    hit_s;
   logic [3:0]  idx_r,    idx_s;
   logic [31:0] ehi_r,    ehi_s;
   logic [3:0]  ridx_r,   ridx_s;
   logic [95:0] entry_r,  entry_s;
   logic        match_s;

   logic [3:0]  rd_idx_r,  rd_idx_s;
   logic        stall_r,   stall_s;
   logic        busy_r,    busy_s;
   logic        we_r,      we_s;
   logic [4:0]  waddr_r,   waddr_s;
   logic [31:0] wdata_r,   wdata_s;
   logic [27:0] unused_index_s;

   tlb_entry_match u_match (
      .entry   (rd_entry_i),
      .entryhi (ehi_r),
      .match   (match_s)
   );

   // Next-state and datapath update; flush overrides every transition.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      hit_s   = hit_r;
      idx_s   = idx_r;
      ehi_s   = ehi_r;
      ridx_s  = ridx_r;
      entry_s = entry_r;
      if (flush_i) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (inst_valid_i && (inst_i == INST_TLBP)) begin
                  ehi_s   = entryhi_i;
                  ptr_s   = 4'd0;
                  state_s = ST_SCAN;
               end else if (inst_valid_i && (inst_i == INST_TLBR)) begin
                  ridx_s  = index_i[3:0];
                  state_s = ST_READ;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (match_s) begin
                  hit_s   = 1'b1;
                  idx_s   = ptr_r;
                  state_s = ST_PDONE;
               end else if (ptr_r == 4'd15) begin
                  hit_s   = 1'b0;
                  state_s = ST_PDONE;
               end else begin
                  ptr_s   = ptr_r + 4'd1;
               end
            end
            ST_PDONE:  state_s = ST_IDLE;
            ST_READ: begin
               entry_s = rd_entry_i;
               state_s = ST_WB_HI;
            end
            ST_WB_HI:  state_s = ST_WB_LO0;
            ST_WB_LO0: state_s = ST_WB_LO1;
            ST_WB_LO1: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
         endcase
      end
   end

   // Output decode of the state being entered, registered below.
   always_comb begin
      rd_idx_s = 4'd0;
      stall_s  = 1'b0;
      busy_s   = (state_s != ST_IDLE);
      we_s     = 1'b0;
      waddr_s  = 5'd0;
      wdata_s  = 32'd0;
      case (state_s)
         ST_SCAN: begin
            rd_idx_s = ptr_s;
            stall_s  = 1'b1;
         end
         ST_PDONE: begin
            we_s    = 1'b1;
            waddr_s = CP0_REG_INDEX;
            wdata_s = probe_result(hit_s, idx_s);
         end
         ST_READ: begin
            rd_idx_s = ridx_s;
            stall_s  = 1'b1;
         end
         ST_WB_HI: begin
            stall_s = 1'b1;
            we_s    = 1'b1;
            waddr_s = CP0_REG_ENTRYHI;
            wdata_s = entry_s[ENT_EHI_HI:ENT_EHI_LO];
         end
         ST_WB_LO0: begin
            stall_s = 1'b1;
            we_s    = 1'b1;
            waddr_s = CP0_REG_ENTRYLO0;
            wdata_s = entry_s[ENT_LO0_HI:ENT_LO0_LO];
         end
         ST_WB_LO1: begin
            we_s    = 1'b1;
            waddr_s = CP0_REG_ENTRYLO1;
            wdata_s = entry_s[ENT_LO1_HI:ENT_LO1_LO];
         end
         default: begin
            rd_idx_s = 4'd0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         ptr_r    <= 4'd0;
         hit_r    <= 1'b0;
         idx_r    <= 4'd0;
         ehi_r    <= 32'd0;
         ridx_r   <= 4'd0;
         entry_r  <= 96'd0;
         rd_idx_r <= 4'd0;
         stall_r  <= 1'b0;
         busy_r   <= 1'b0;
         we_r     <= 1'b0;
         waddr_r  <= 5'd0;
         wdata_r  <= 32'd0;
      end else begin
         state_r  <= state_s;
         ptr_r    <= ptr_s;
         hit_r    <= hit_s;
         idx_r    <= idx_s;
         ehi_r    <= ehi_s;
         ridx_r   <= ridx_s;
         entry_r  <= entry_s;
         rd_idx_r <= rd_idx_s;
         stall_r  <= stall_s;
         busy_r   <= busy_s;
         we_r     <= we_s;
         waddr_r  <= waddr_s;
         wdata_r  <= wdata_s;
      end
   end

   assign rd_idx_o    = rd_idx_r;
   assign stall_req_o = stall_r;
   assign busy_o      = busy_r;
   // A flush or reset in the write cycle cancels the write immediately.
   assign cp0_we_o    = we_r & ~flush_i & rst;
   assign cp0_waddr_o = waddr_r;
   assign cp0_wdata_o = wdata_r;

   assign unused_index_s = index_i[31:4];

endmodule

// File: tb/tb_tlb_query.sv
module tb_tlb_query;

   localparam logic [31:0] OP_TLBP = 32'h4200_0008;
   localparam logic [31:0] OP_TLBR = 32'h4200_0001;

   logic        clk;
   logic        rst;
   logic [31:0] inst_i;
   logic        inst_valid_i;
   logic        flush_i;
   logic [31:0] index_i;
   logic [31:0] entryhi_i;
   logic [3:0]  rd_idx_o;
   logic [95:0] rd_entry_i;
   logic        stall_req_o;
   logic        busy_o;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_wdata_o;

   logic [95:0] tlb [16];

   int total = 0;
   int bad   = 0;

   int          busy_cnt;
   int          stall_cnt;
   int          n_wr;
   logic        timed_out;
   logic [4:0]  wr_addr [8];
   logic [31:0] wr_data [8];

   tlb_query dut (
      .clk          (clk),
      .rst          (rst),
      .inst_i       (inst_i),
      .inst_valid_i (inst_valid_i),
      .flush_i      (flush_i),
      .index_i      (index_i),
      .entryhi_i    (entryhi_i),
      .rd_idx_o     (rd_idx_o),
      .rd_entry_i   (rd_entry_i),
      .stall_req_o  (stall_req_o),
      .busy_o       (busy_o),
      .cp0_we_o     (cp0_we_o),
      .cp0_waddr_o  (cp0_waddr_o),
      .cp0_wdata_o  (cp0_wdata_o)
   );

   assign rd_entry_i = tlb[rd_idx_o];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: lowest index whose VPN2 and ASID equal the probed EntryHi, -1 if none.
   function automatic int ref_probe(input logic [31:0] ehi);
      for (int k = 0; k < 16; k++) begin
         if (tlb[k][95:77] == ehi[31:13] && tlb[k][71:64] == ehi[7:0]) return k;
      end
      return -1;
   endfunction

   // Random contents; with no_asid set, every ASID is 0 so a nonzero probe ASID cannot hit.
   task automatic fill_tlb(input bit no_asid);
      for (int k = 0; k < 16; k++) begin
         tlb[k] = {$urandom(), $urandom(), $urandom()};
         if (no_asid) tlb[k][71:64] = 8'h00;
      end
   endtask

   task automatic plant(input int k, input logic [31:0] ehi);
      tlb[k][95:77] = ehi[31:13];
      tlb[k][71:64] = ehi[7:0];
   endtask

   // Present one instruction for one cycle; returns at the first sample point after it.
   task automatic issue(input logic [31:0] op, input logic [31:0] ehi, input logic [31:0] idx);
      @(negedge clk);
      inst_i       = op;
      inst_valid_i = 1'b1;
      entryhi_i    = ehi;
      index_i      = idx;
      @(negedge clk);
      inst_valid_i = 1'b0;
      inst_i       = 32'd0;
   endtask

   // Record activity at each negedge until busy drops (bounded).
   task automatic collect();
      busy_cnt  = 0;
      stall_cnt = 0;
      n_wr      = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_addr[i] = 'x;
         wr_data[i] = 'x;
      end
      for (int c = 0; c < 40; c++) begin
         if (!busy_o) begin
            timed_out = 1'b0;
            break;
         end
         busy_cnt++;
         if (stall_req_o) stall_cnt++;
         if (cp0_we_o) begin
            if (n_wr < 8) begin
               wr_addr[n_wr] = cp0_waddr_o;
               wr_data[n_wr] = cp0_wdata_o;
            end
            n_wr++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_probe_case(input string name, input logic [31:0] ehi);
      int          k;
      logic [31:0] exp_data;
      int          exp_busy;
      int          exp_stall;
      k = ref_probe(ehi);
      exp_data  = (k >= 0) ? 32'(k) : 32'h8000_0000;
      exp_stall = (k >= 0) ? k + 1 : 16;
      exp_busy  = exp_stall + 1;
      issue(OP_TLBP, ehi, $urandom());
      collect();
      total++; if (timed_out) begin bad++; $display("FAIL %s timeout: busy still 1 after 40 cycles", name); end
      total++; if (n_wr !== 1) begin bad++; $display("FAIL %s write count: got %0d need 1", name, n_wr); end
      total++; if (wr_addr[0] !== 5'd0) begin bad++; $display("FAIL %s waddr: got %0d need 0", name, wr_addr[0]); end
      total++; if (wr_data[0] !== exp_data) begin bad++; $display("FAIL %s index data: got %h need %h", name, wr_data[0], exp_data); end
      total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL %s stall cycles: got %0d need %0d", name, stall_cnt, exp_stall); end
      total++; if (busy_cnt !== exp_busy) begin bad++; $display("FAIL %s busy cycles: got %0d need %0d", name, busy_cnt, exp_busy); end
   endtask

   task automatic test_read_case(input string name, input logic [3:0] idx);
      logic [31:0] r;
      logic [95:0] e;
      r = $urandom();
      r[3:0] = idx;
      e = tlb[idx];
      issue(OP_TLBR, $urandom(), r);
      collect();
      total++; if (timed_out) begin bad++; $display("FAIL %s timeout: busy still 1", name); end
      total++; if (n_wr !== 3) begin bad++; $display("FAIL %s write count: got %0d need 3", name, n_wr); end
      total++; if (wr_addr[0] !== 5'd10 || wr_data[0] !== e[95:64])
         begin bad++; $display("FAIL %s entryhi write: got %0d/%h need 10/%h", name, wr_addr[0], wr_data[0], e[95:64]); end
      total++; if (wr_addr[1] !== 5'd2 || wr_data[1] !== e[63:32])
         begin bad++; $display("FAIL %s entrylo0 write: got %0d/%h need 2/%h", name, wr_addr[1], wr_data[1], e[63:32]); end
      total++; if (wr_addr[2] !== 5'd3 || wr_data[2] !== e[31:0])
         begin bad++; $display("FAIL %s entrylo1 write: got %0d/%h need 3/%h", name, wr_addr[2], wr_data[2], e[31:0]); end
      total++; if (stall_cnt !== 3) begin bad++; $display("FAIL %s stall cycles: got %0d need 3", name, stall_cnt); end
      total++; if (busy_cnt !== 4) begin bad++; $display("FAIL %s busy cycles: got %0d need 4", name, busy_cnt); end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy_o, stall_req_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o, rd_idx_o} !== 43'd0) begin
         bad++;
         $display("FAIL reset outputs: got busy=%b stall=%b we=%b waddr=%0d wdata=%h rd_idx=%0d need all 0",
                  busy_o, stall_req_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o, rd_idx_o);
      end
   endtask

   task automatic test_probe_fixed();
      fill_tlb(1'b1);
      tlb[5][95:77] = 19'h00400;
      tlb[5][71:64] = 8'h12;
      test_probe_case("probe_hit5", 32'h0080_0012);
   endtask

   task automatic test_probe_miss();
      fill_tlb(1'b1);
      test_probe_case("probe_miss", 32'h1234_5077);
   endtask

   task automatic test_probe_multi();
      fill_tlb(1'b1);
      plant(3, 32'h5555_A0C3);
      plant(9, 32'h5555_A0C3);
      test_probe_case("probe_multi", 32'h5555_A0C3);
      plant(0, 32'h0000_2001);
      test_probe_case("probe_hit0", 32'h0000_2001);
      plant(15, 32'hFFFF_E0FE);
      test_probe_case("probe_hit15", 32'hFFFF_E0FE);
   endtask

   task automatic test_read_fixed();
      fill_tlb(1'b0);
      tlb[7] = 96'hAAAA0011_BBBB0003_CCCC0002;
      test_read_case("read7", 4'd7);
   endtask

   task automatic test_random();
      logic [31:0] ehi;
      int          k;
      for (int it = 0; it < 24; it++) begin
         fill_tlb(1'b0);
         ehi = $urandom();
         if ($urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, 15);
            plant(k, ehi);
            if ($urandom_range(0, 1) == 1) plant($urandom_range(k, 15), ehi);
         end
         test_probe_case("probe_rand", ehi);
         test_read_case("read_rand", 4'($urandom_range(0, 15)));
      end
   endtask

   task automatic test_ignore();
      logic [31:0] op;
      op = 32'h4200_0002;
      issue(op, 32'd0, 32'd0);
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ignore_other busy: got %b need 0", busy_o); end
      // A TLBR held valid during a probe must not disturb it.
      fill_tlb(1'b1);
      issue(OP_TLBP, 32'h0000_0042, 32'd0);
      inst_i       = OP_TLBR;
      inst_valid_i = 1'b1;
      index_i      = 32'd7;
      collect();
      inst_valid_i = 1'b0;
      inst_i       = 32'd0;
      total++; if (n_wr !== 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h8000_0000)
         begin bad++; $display("FAIL ignore_busy write: got n=%0d %0d/%h need 1 0/80000000", n_wr, wr_addr[0], wr_data[0]); end
      total++; if (busy_cnt !== 17) begin bad++; $display("FAIL ignore_busy busy cycles: got %0d need 17", busy_cnt); end
      @(negedge clk);
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ignore_busy after: busy got %b need 0", busy_o); end
   endtask

   task automatic test_flush();
      bit seen;
      fill_tlb(1'b1);
      issue(OP_TLBP, 32'h0000_0033, 32'd0);
      @(negedge clk);
      @(negedge clk);
      // Third SCAN cycle: flush together with a fresh TLBP.
      flush_i      = 1'b1;
      inst_i       = OP_TLBP;
      inst_valid_i = 1'b1;
      #1;
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL flush scan busy: got %b need 1", busy_o); end
      total++; if (cp0_we_o !== 1'b0) begin bad++; $display("FAIL flush we: got %b need 0", cp0_we_o); end
      @(negedge clk);
      flush_i      = 1'b0;
      inst_valid_i = 1'b0;
      inst_i       = 32'd0;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush idle: busy got %b need 0", busy_o); end
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (busy_o || cp0_we_o) seen = 1'b1;
         @(negedge clk);
      end
      total++; if (seen) begin bad++; $display("FAIL flush quiet: activity got 1 need 0"); end
   endtask

   task automatic test_flush_pdone();
      fill_tlb(1'b1);
      plant(0, 32'h0000_4009);
      issue(OP_TLBP, 32'h0000_4009, 32'd0);
      @(negedge clk);
      total++; if (cp0_we_o !== 1'b1) begin bad++; $display("FAIL pdone we before flush: got %b need 1", cp0_we_o); end
      flush_i = 1'b1;
      #1;
      total++; if (cp0_we_o !== 1'b0) begin bad++; $display("FAIL pdone flush we: got %b need 0", cp0_we_o); end
      @(negedge clk);
      flush_i = 1'b0;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL pdone flush busy: got %b need 0", busy_o); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      fill_tlb(1'b0);
      issue(OP_TLBR, 32'd0, 32'd4);
      @(negedge clk);
      total++; if (cp0_we_o !== 1'b1 || cp0_waddr_o !== 5'd10 || cp0_wdata_o !== tlb[4][95:64])
         begin bad++; $display("FAIL rstmid entryhi: got %b %0d/%h need 1 10/%h", cp0_we_o, cp0_waddr_o, cp0_wdata_o, tlb[4][95:64]); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (cp0_we_o !== 1'b0) begin bad++; $display("FAIL rstmid lo0 we: got %b need 0", cp0_we_o); end
      @(negedge clk);
      rst = 1'b1;
      total++; if (busy_o !== 1'b0 || stall_req_o !== 1'b0) begin bad++; $display("FAIL rstmid busy/stall: got %b/%b need 0/0", busy_o, stall_req_o); end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (cp0_we_o) seen = 1'b1;
         @(negedge clk);
      end
      total++; if (seen) begin bad++; $display("FAIL rstmid late write: got 1 need 0"); end
   endtask

   initial begin
      rst          = 1'b0;
      inst_i       = 32'd0;
      inst_valid_i = 1'b0;
      flush_i      = 1'b0;
      index_i      = 32'd0;
      entryhi_i    = 32'd0;
      for (int k = 0; k < 16; k++) tlb[k] = 96'd0;
      test_reset();
      test_probe_fixed();
      test_probe_miss();
      test_probe_multi();
      test_read_fixed();
      test_random();
      test_ignore();
      test_flush();
      test_flush_pdone();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
